// File: rtl/fft_unload_pkg.sv
// Shared definitions for the FFT output reorder buffer:
// default frame length, word width and FILL/DRAIN state encoding.
package fft_unload_pkg;

   localparam int DEF_LOG_N = 3;
   localparam int DEF_W     = 64;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

endpackage

// File: rtl/fft_unload_bit_reverse.sv
// Combinational bit reversal of an index; forms the write address so that
// samples arriving in bit-reversed order land at their natural address.
module fft_unload_bit_reverse #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_rev
         assign dout[gi] = din[WIDTH-1-gi];
      end
   endgenerate

endmodule

// File: rtl/fft_unload.sv
// fft_unload: output reorder buffer between the last butterfly stage and the
// result consumer. Accepts N = 2^LOG_N samples in bit-reversed order, stores
// sample k at address bitrev(k) and streams the frame out in natural order.
// Optional feature: define FFT_UNLOAD_PINGPONG_EN for a two-bank build that
// fills one bank while the other drains (sustained 1 sample/cycle).
module fft_unload
   import fft_unload_pkg::*;
#(
   parameter int LOG_N = DEF_LOG_N,
   parameter int W     = DEF_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_re,
   input  logic [W-1:0]     in_im,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_re,
   output logic [W-1:0]     out_im,
   output logic [LOG_N-1:0] out_idx,
   output logic             out_last,
   output logic             err
);

   localparam int N = 1 << LOG_N;
   localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);
   localparam logic [LOG_N-1:0] ONE_IDX  = LOG_N'(1);
`ifdef FFT_UNLOAD_PINGPONG_EN
   localparam int AW = LOG_N + 1;   // top address bit selects the bank
`else
   localparam int AW = LOG_N;
`endif
   localparam int DEPTH = 1 << AW;

   // {re, im} per entry; never reset, stale contents are harmless
   logic [2*W-1:0]   mem [DEPTH];

   logic [LOG_N-1:0] wr_cnt_reg;
   logic [LOG_N-1:0] rd_cnt_reg;
   logic [LOG_N-1:0] wr_bitrev;
   logic [AW-1:0]    wr_mem_addr;
   logic [AW-1:0]    rd_mem_addr;
   logic [2*W-1:0]   rd_word;
   logic             in_fire;
   logic             out_fire;
   logic             wr_is_last;

   logic             out_valid_reg;
   logic             out_last_reg;
   logic [W-1:0]     out_re_reg;
   logic [W-1:0]     out_im_reg;
   logic [LOG_N-1:0] out_idx_reg;
   logic             err_reg;

   fft_unload_bit_reverse #(
      .WIDTH (LOG_N)
   ) u_bitrev (
      .din  (wr_cnt_reg),
      .dout (wr_bitrev)
   );

   assign in_fire    = in_valid && in_ready;
   assign out_fire   = out_valid_reg && out_ready;
   assign wr_is_last = (wr_cnt_reg == LAST_IDX);
   assign rd_word    = mem[rd_mem_addr];

   assign out_valid = out_valid_reg;
   assign out_re    = out_re_reg;
   assign out_im    = out_im_reg;
   assign out_idx   = out_idx_reg;
   assign out_last  = out_last_reg;
   assign err       = err_reg;

   // Sample storage: write each accepted sample at its bit-reversed slot
   always_ff @(posedge clk) begin
      if (in_fire) begin
         mem[wr_mem_addr] <= {in_re, in_im};
      end
   end

   // Input counter and sticky framing check (in_last must mark exactly k == N-1)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt_reg <= '0;
         err_reg    <= 1'b0;
      end else if (in_fire) begin
         wr_cnt_reg <= wr_cnt_reg + ONE_IDX;
         if (in_last != wr_is_last) begin
            err_reg <= 1'b1;
         end
      end
   end

`ifdef FFT_UNLOAD_PINGPONG_EN

   logic fill_bank_reg;   // bank currently being written; the other drains
   logic fill_full_reg;   // fill bank holds a full frame, waiting for drain
   logic fill_done;
   logic drain_free;
   logic swap;

   assign in_ready    = !fill_full_reg;
   assign fill_done   = fill_full_reg || (in_fire && wr_is_last);
   assign drain_free  = !out_valid_reg || (out_fire && out_last_reg);
   assign swap        = fill_done && drain_free;
   assign wr_mem_addr = {fill_bank_reg, wr_bitrev};
   // On a swap the first output comes from the bank that just filled
   assign rd_mem_addr = swap ? {fill_bank_reg, {LOG_N{1'b0}}}
                             : {~fill_bank_reg, rd_cnt_reg};

   // Bank swap and output register control for the two-bank build
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_bank_reg <= 1'b0;
         fill_full_reg <= 1'b0;
         rd_cnt_reg    <= '0;
         out_valid_reg <= 1'b0;
         out_re_reg    <= '0;
         out_im_reg    <= '0;
         out_idx_reg   <= '0;
         out_last_reg  <= 1'b0;
      end else if (swap) begin
         fill_bank_reg <= ~fill_bank_reg;
         fill_full_reg <= 1'b0;
         out_valid_reg <= 1'b1;
         out_re_reg    <= rd_word[2*W-1:W];
         out_im_reg    <= rd_word[W-1:0];
         out_idx_reg   <= '0;
         out_last_reg  <= 1'b0;
         rd_cnt_reg    <= ONE_IDX;
      end else begin
         if (in_fire && wr_is_last) begin
            fill_full_reg <= 1'b1;
         end
         if (out_fire) begin
            if (out_last_reg) begin
               out_valid_reg <= 1'b0;
               rd_cnt_reg    <= '0;
            end else begin
               out_re_reg   <= rd_word[2*W-1:W];
               out_im_reg   <= rd_word[W-1:0];
               out_idx_reg  <= rd_cnt_reg;
               out_last_reg <= (rd_cnt_reg == LAST_IDX);
               rd_cnt_reg   <= rd_cnt_reg + ONE_IDX;
            end
         end
      end
   end

`else

   state_t state_reg;
   logic   in_ready_reg;

   assign in_ready    = in_ready_reg;
   assign wr_mem_addr = wr_bitrev;
   // rd_cnt is 0 throughout FILL, so the first read is mem[0]
   assign rd_mem_addr = rd_cnt_reg;

   // FILL/DRAIN sequencer with registered handshake and output data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= FILL;
         in_ready_reg  <= 1'b1;
         rd_cnt_reg    <= '0;
         out_valid_reg <= 1'b0;
         out_re_reg    <= '0;
         out_im_reg    <= '0;
         out_idx_reg   <= '0;
         out_last_reg  <= 1'b0;
      end else begin
         case (state_reg)
            FILL: begin
               if (in_fire && wr_is_last) begin
                  state_reg     <= DRAIN;
                  in_ready_reg  <= 1'b0;
                  out_valid_reg <= 1'b1;
                  out_re_reg    <= rd_word[2*W-1:W];
                  out_im_reg    <= rd_word[W-1:0];
                  out_idx_reg   <= '0;
                  out_last_reg  <= 1'b0;
                  rd_cnt_reg    <= ONE_IDX;
               end
            end
            DRAIN: begin
               if (out_fire) begin
                  if (out_last_reg) begin
                     state_reg     <= FILL;
                     in_ready_reg  <= 1'b1;
                     out_valid_reg <= 1'b0;
                     rd_cnt_reg    <= '0;
                  end else begin
                     out_re_reg   <= rd_word[2*W-1:W];
                     out_im_reg   <= rd_word[W-1:0];
                     out_idx_reg  <= rd_cnt_reg;
                     out_last_reg <= (rd_cnt_reg == LAST_IDX);
                     rd_cnt_reg   <= rd_cnt_reg + ONE_IDX;
                  end
               end
            end
            default: begin
               state_reg <= FILL;
            end
         endcase
      end
   end

`endif

endmodule

// File: tb/tb_fft_unload.sv
// Self-checking bench for fft_unload (LOG_N = 3, W = 64). The driver feeds a
// reference model that places the k-th sample of a frame at natural index
// bitrev(k) and queues the natural-order frame; a monitor pops and compares
// every accepted output.
module tb_fft_unload;

   localparam int LOG_N = 3;
   localparam int N     = 1 << LOG_N;
   localparam int W     = 64;

   typedef struct {
      logic [W-1:0]     re;
      logic [W-1:0]     im;
      logic [LOG_N-1:0] idx;
      logic             last;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_re;
   logic [W-1:0]     in_im;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_re;
   logic [W-1:0]     out_im;
   logic [LOG_N-1:0] out_idx;
   logic             out_last;
   logic             err;

   int   checks   = 0;
   int   failures = 0;

   exp_t exp_q[$];
   logic exp_err = 1'b0;
   int   mk = 0;
   logic [W-1:0] nat_re [N];
   logic [W-1:0] nat_im [N];

   logic rand_ready = 1'b0;
   logic cnt_en     = 1'b0;
   int   lowcnt     = 0;
   int   gapcnt     = 0;
   logic seen_out   = 1'b0;

   logic             stall = 1'b0;
   logic [W-1:0]     h_re, h_im;
   logic [LOG_N-1:0] h_idx;
   logic             h_last;

   fft_unload #(
      .LOG_N (LOG_N),
      .W     (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .err       (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic int bitrev(input int k);
      int r = 0;
      for (int b = 0; b < LOG_N; b++) begin
         if ((k >> b) & 1) r = r | (1 << (LOG_N - 1 - b));
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: the k-th sample of a frame belongs at natural index bitrev(k)
   task automatic model_accept(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
      exp_t e;
      if (last != (mk == N - 1)) exp_err = 1'b1;
      nat_re[bitrev(mk)] = re;
      nat_im[bitrev(mk)] = im;
      mk++;
      if (mk == N) begin
         for (int n = 0; n < N; n++) begin
            e.re   = nat_re[n];
            e.im   = nat_im[n];
            e.idx  = LOG_N'(n);
            e.last = (n == N - 1);
            exp_q.push_back(e);
         end
         mk = 0;
      end
   endtask

   // Called at a negedge; returns at the negedge after the transfer edge
   task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
      int t = 0;
      in_re    = re;
      in_im    = im;
      in_last  = last;
      in_valid = 1'b1;
      while (!in_ready) begin
         @(negedge clk);
         t++;
         if (t > 200) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 required=1");
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      model_accept(re, im, last);
      $display("IN  k=%0d re=%0h im=%0h last=%0d", (mk + N - 1) % N, re, im, last);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("drain_done", W'(t < 500), W'(1));
   endtask

   task automatic check_reset_outputs(input string tag);
      #1;
      chk({tag, "_in_ready"},  W'(in_ready),  W'(1));
      chk({tag, "_out_valid"}, W'(out_valid), W'(0));
      chk({tag, "_out_re"},    out_re,        W'(0));
      chk({tag, "_out_im"},    out_im,        W'(0));
      chk({tag, "_out_idx"},   W'(out_idx),   W'(0));
      chk({tag, "_out_last"},  W'(out_last),  W'(0));
      chk({tag, "_err"},       W'(err),       W'(0));
   endtask

   function automatic logic [W-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Random consumer backpressure when enabled
   always @(negedge clk) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Back-to-back measurement: in_ready low cycles and out_valid gaps
   always @(negedge clk) begin
      #1;
      if (cnt_en) begin
         if (!in_ready) lowcnt++;
         if (out_valid) seen_out = 1'b1;
         else if (seen_out) gapcnt++;
      end
   end

   // Monitor: compare each accepted output with the scoreboard; check hold and err
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (!rst_n) begin
         stall = 1'b0;
      end else begin
         chk("err_flag", W'(err), W'(exp_err));
         if (stall) begin
            checks++;
            if (!out_valid || out_re !== h_re || out_im !== h_im ||
                out_idx !== h_idx || out_last !== h_last) begin
               failures++;
               $display("FAIL hold_stable actual=v%0d idx%0d re=%0h required=v1 idx%0d re=%0h",
                        out_valid, out_idx, out_re, h_idx, h_re);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_output actual=idx%0d re=%0h required=no output",
                        out_idx, out_re);
            end else begin
               e = exp_q.pop_front();
               if (out_re !== e.re || out_im !== e.im || out_idx !== e.idx || out_last !== e.last) begin
                  failures++;
                  $display("FAIL out_sample actual=idx%0d re=%0h im=%0h last=%0d required=idx%0d re=%0h im=%0h last=%0d",
                           out_idx, out_re, out_im, out_last, e.idx, e.re, e.im, e.last);
               end else begin
                  $display("OUT idx=%0d re=%0h im=%0h last=%0d", out_idx, out_re, out_im, out_last);
               end
            end
         end
         stall  = out_valid && !out_ready;
         h_re   = out_re;
         h_im   = out_im;
         h_idx  = out_idx;
         h_last = out_last;
      end
   end

   int order [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_re     = '0;
      in_im     = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Natural-order reconstruction and first-output latency
      for (int k = 0; k < N; k++) send(W'(order[k]), W'(100 + order[k]), k == N - 1);
      #1;
      chk("latency_valid", W'(out_valid), W'(1));
      chk("latency_idx",   W'(out_idx),   W'(0));
      @(negedge clk);
      wait_drain();
      idle(2);

      // Output backpressure at idx 2 for 3 cycles
      for (int k = 0; k < N; k++) send(W'(order[k]), W'(100 + order[k]), k == N - 1);
      in_valid = 1'b0;
      begin
         int t = 0;
         while (!(out_valid && out_idx == 2) && t < 50) begin
            @(negedge clk);
            t++;
         end
         chk("bp_reach_idx2", W'(t < 50), W'(1));
      end
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_hold_re",  out_re,       W'(2));
         chk("bp_hold_idx", W'(out_idx),  W'(2));
         @(negedge clk);
      end
      out_ready = 1'b1;
      wait_drain();

      // Framing error: in_last on the 5th sample, frame still closes after N
      for (int k = 0; k < N; k++) begin
         send(rnd64(), rnd64(), k == 4);
         if (k == 4) begin
            #1;
            chk("err_next_cycle", W'(err), W'(1));
         end
      end
      wait_drain();
      for (int k = 0; k < N; k++) send(rnd64(), rnd64(), k == N - 1);
      wait_drain();
      chk("err_persists", W'(err), W'(1));

      // Reset after 5 inputs discards the partial frame
      for (int k = 0; k < 5; k++) send(rnd64(), rnd64(), 1'b0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      mk       = 0;
      exp_err  = 1'b0;
      check_reset_outputs("midrst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < N; k++) send(rnd64(), rnd64(), k == N - 1);
      wait_drain();

      // Randomized frames with input gaps and random output backpressure
      rand_ready = 1'b1;
      for (int f = 0; f < 4; f++) begin
         for (int k = 0; k < N; k++) begin
            int g = $urandom_range(0, 2);
            if (g > 0) idle(g);
            send(rnd64(), rnd64(), k == N - 1);
         end
      end
      in_valid = 1'b0;
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      wait_drain();
      idle(1);

      // Back-to-back frames with in_valid held high
      lowcnt   = 0;
      gapcnt   = 0;
      seen_out = 1'b0;
      cnt_en   = 1'b1;
      for (int k = 0; k < 2 * N; k++) send(rnd64(), rnd64(), (k % N) == N - 1);
      cnt_en   = 1'b0;
      in_valid = 1'b0;
`ifdef FFT_UNLOAD_PINGPONG_EN
      chk("b2b_in_ready_low_cycles", W'(lowcnt), W'(0));
      chk("b2b_out_valid_gaps",      W'(gapcnt), W'(0));
`else
      chk("b2b_in_ready_low_cycles", W'(lowcnt), W'(N));
`endif
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
